// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
//   MEM-stage controller that serves 32-bit loads/stores from the execute stage
//   through a 16-bit external SRAM. Each access is two halfword phases, low
//   half first, and each phase lasts WAIT_CYCLES cycles. The pipeline is frozen
//   with ready=0 while an access is in flight.
// Ports
//   clk, rst        clock, synchronous active-low reset
//   MEM_R_en/W_EN   load/store request (a store wins if both are set)
//   ALU_Res         byte address; BASE_ADDR maps to SRAM word 0
//   Val_Rm          store data
//   mem_rdata       last completed load result
//   ready           0 = freeze the pipeline
//   SRAM_*          external halfword SRAM interface (active-low strobes)
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_en,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_Res,
    input  logic [31:0]        Val_Rm,
    output logic [31:0]        mem_rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_WDATA,
    input  logic [15:0]        SRAM_RDATA,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        data_q;
    logic               wr_q;
    logic [31:0]        rbuf_q;
    logic               we_n_q;
    logic               oe_n_q;

    logic               req;
    logic               last;
    logic [31:0]        offs;
    logic [SRAM_AW-2:0] word_in;
    logic               unused_offs;

    assign req     = MEM_R_en | MEM_W_EN;
    assign last    = (cnt_q == CNT_LAST);
    // Offset wraps mod 2^32; only the word bits that fit the SRAM are kept.
    assign offs    = ALU_Res - 32'(BASE_ADDR);
    assign word_in = offs[SRAM_AW:2];
    assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};

    // ready drops combinationally on a new request so the pipeline freezes
    // in the same cycle; during reset it only reflects the request.
    assign ready = ((state_q == IDLE || !rst) && !req) || (state_q == DONE);

    // Strobes are forced off by reset immediately, so the halfword in flight
    // when reset arrives is never written at the reset edge.
    assign SRAM_WE_N = we_n_q | ~rst;
    assign SRAM_OE_N = oe_n_q | ~rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            rbuf_q     <= '0;
            mem_rdata  <= '0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        word_q    <= word_in;
                        data_q    <= Val_Rm;
                        wr_q      <= MEM_W_EN;
                        cnt_q     <= '0;
                        state_q   <= LOW;
                        SRAM_ADDR <= {word_in, 1'b0};
                        if (MEM_W_EN) begin
                            SRAM_WDATA <= Val_Rm[15:0];
                            we_n_q     <= 1'b0;
                        end else begin
                            oe_n_q     <= 1'b0;
                        end
                    end
                end
                LOW: begin
                    if (last) begin
                        if (!wr_q) rbuf_q[15:0] <= SRAM_RDATA;
                        cnt_q      <= '0;
                        state_q    <= HIGH;
                        SRAM_ADDR  <= {word_q, 1'b1};
                        SRAM_WDATA <= wr_q ? data_q[31:16] : 16'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HIGH: begin
                    if (last) begin
                        // mem_rdata takes the full word on entry to DONE.
                        if (!wr_q) begin
                            rbuf_q[31:16] <= SRAM_RDATA;
                            mem_rdata     <= {SRAM_RDATA, rbuf_q[15:0]};
                        end
                        cnt_q      <= '0;
                        state_q    <= DONE;
                        we_n_q     <= 1'b1;
                        oe_n_q     <= 1'b1;
                        SRAM_ADDR  <= '0;
                        SRAM_WDATA <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
